truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Synthesizable exhaustive-stimulus engine that replaces hand-written `for` sweeps over a combinational circuit's inputs. On `start` it walks every N_IN-bit input vector in binary or Gray order and drives each onto `vec_out`. After a programmable settle time it compares the circuit's output against a golden-model output and counts mismatches. It sits between a combinational circuit under test and its reference model, in simulation benches or on-board self-test.

## Interface

**Parameters**
- `N_IN`, 4: input vector width; 2^N_IN vectors are swept.
- `N_OUT`, 1: width of the compared outputs.
- `SETTLE`, 2: clock cycles each vector is held before comparison; legal range is 1 to 255.

**Ports**
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: begins a sweep; honoured only in IDLE or DONE.
- `mode` in 1: 0 = ascending binary order, 1 = Gray-code order; sampled on the accepted `start`.
- `vec_out` out N_IN: stimulus driven to the circuit under test and to the reference model.
- `dut_f` in N_OUT: output of the circuit under test.
- `ref_f` in N_OUT: output of the golden model.
- `busy` out 1: high while the sweep is in SETTLE or CHECK.
- `done` out 1: level signal, high in DONE until the next accepted `start` or `rst`.
- `pass` out 1: valid when `done` is high; 1 means `err_count` == 0.
- `err_count` out N_IN+1: number of mismatching vectors.
- `first_fail_valid` out 1: high once any mismatch has been recorded.
- `first_fail_vec` out N_IN: `vec_out` value at the first mismatch.

## Operation

- **FSM states:** IDLE, SETTLE, CHECK, DONE.
- **IDLE → SETTLE** on `start`:
  - `idx` ← 0 and `vec_out` ← code(0).
  - `mode` is latched.
  - `err_count`, `first_fail_valid` and `first_fail_vec` are cleared.
  - The settle counter ← 0.
- **SETTLE:** the counter increments each cycle. When it reaches SETTLE-1 the FSM moves to CHECK. `vec_out` is held constant.
- **CHECK** (exactly one cycle):
  - If `dut_f` != `ref_f`, `err_count` increments. On the first mismatch, `first_fail_vec` ← `vec_out` and `first_fail_valid` ← 1.
  - If `idx` == 2^N_IN-1, the FSM moves to DONE.
  - Otherwise `idx` increments, `vec_out` ← code(idx+1), the counter is cleared and the FSM returns to SETTLE.
- **DONE:** `done` = 1 and `pass` = (`err_count` == 0). `start` restarts exactly as from IDLE, and `done` drops on that same edge.
- **Encoding:** code(i) = i in binary mode, and i ^ (i >> 1) in Gray mode.
- **Ignored inputs:** `start` is ignored while `busy`. `mode` changes during a sweep have no effect.
- **Counter width:** `err_count` is N_IN+1 bits wide, so it can never overflow (maximum 2^N_IN). No saturation logic is needed.
- **Comparison:** compare the full N_OUT bits with `!=`. No X handling is required in RTL.

## Timing

- **Reset values:** `vec_out` = 0, `busy` = 0, `done` = 0, `pass` = 0, `err_count` = 0, `first_fail_valid` = 0, `first_fail_vec` = 0. The FSM is in IDLE.
- **Start latency:** `start` sampled high at edge k sets `busy` = 1 and `vec_out` = code(0) after edge k.
- **Per-vector time:** SETTLE+1 cycles, made of SETTLE cycles in SETTLE plus 1 in CHECK.
- **Comparison point:** `dut_f`/`ref_f` are sampled at the end of the CHECK cycle, SETTLE+1 edges after `vec_out` changed.
- **Sweep length:** 2^N_IN·(SETTLE+1) cycles from the first `busy` cycle to the first `done` cycle. With defaults that is 48 cycles.
- **Done handoff:** `done` rises on the same edge that `busy` falls, and `err_count` is final on that edge.
- **Reset mid-sweep:** `rst` on any edge aborts to IDLE with the reset values. Partial results are discarded.
- **Simultaneous events:** `rst` and `start` on the same edge: `rst` wins.

## Structure

- Shared header `sweeper_defs.vh` holds:
  - the state encodings (2-bit: IDLE = 0, SETTLE = 1, CHECK = 2, DONE = 3);
  - the mode constants `MODE_BIN` = 0 and `MODE_GRAY` = 1.
- One sub-module, `gray_encode`: parameter N, input `bin[N-1:0]`, output `gray[N-1:0]`, purely combinational. It is instantiated once, and its result is muxed with `idx` by the latched mode.
- All other logic lives in a single module: FSM, settle counter, `idx` counter and result registers.

## Test plan

- **Clean pass, binary mode:** defaults, `ref_f` and `dut_f` from identical 4-input functions, `mode` = 0 → `vec_out` steps 0..15 every 3 cycles; `done` is reached after 48 busy cycles; `pass` = 1; `err_count` = 0.
- **Single fault:** `dut_f` differs from `ref_f` only at vector 9 → `err_count` = 1, `first_fail_valid` = 1, `first_fail_vec` = 9, `pass` = 0.
- **Gray order:** `mode` = 1 → `vec_out` sequence is 0,1,3,2,6,7,5,4,12,…,8; successive values differ in exactly one bit. With `dut_f` = ~`ref_f`, `err_count` = 16.
- **Restart and ignore:** `start` pulsed mid-sweep is ignored (vector sequence unchanged). `start` in DONE drops `done`, clears `err_count` and restarts at `vec_out` = 0.
- **Reset mid-sweep:** `rst` asserted at vector 7 → the next cycle shows the reset values on every output and the FSM in IDLE. A following `start` completes a full sweep normally.
- **Parameter corners:**
  - N_IN = 1, SETTLE = 1: sweep lasts 4 cycles.
  - N_IN = 6, N_OUT = 3, SETTLE = 5: sweep lasts 384 cycles; a mismatch at every odd vector gives `err_count` = 32.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper_pkg
// Description : Shared FSM state encodings and sweep-order mode constants
//               for the truth-table sweeper.
// Revision    : 1.0 - initial release
// ============================================================================
package truth_table_sweeper_pkg;

    // Sweeper FSM states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Sweep order selected by the mode input
    localparam logic MODE_BIN  = 1'b0;
    localparam logic MODE_GRAY = 1'b1;

endpackage : truth_table_sweeper_pkg
`default_nettype wire

// File: rtl/truth_table_sweeper_if.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper_if
// Description : Control/status and stimulus/response bundle between the
//               sweeper (slave) and the bench or SoC that drives it (master).
// Revision    : 1.0 - initial release
// ============================================================================
interface truth_table_sweeper_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1
) ();

    logic              start;
    logic              mode;
    logic [N_IN-1:0]   vec_out;
    logic [N_OUT-1:0]  dut_f;
    logic [N_OUT-1:0]  ref_f;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     err_count;
    logic              first_fail_valid;
    logic [N_IN-1:0]   first_fail_vec;

    // Sweeper side
    modport slave (
        input  start, mode, dut_f, ref_f,
        output vec_out, busy, done, pass, err_count,
               first_fail_valid, first_fail_vec
    );

    // Controller / environment side
    modport master (
        output start, mode, dut_f, ref_f,
        input  vec_out, busy, done, pass, err_count,
               first_fail_valid, first_fail_vec
    );

endinterface : truth_table_sweeper_if
`default_nettype wire

// File: rtl/truth_table_sweeper_gray_encode.sv
`default_nettype none
// ============================================================================
// Module      : gray_encode
// Description : Purely combinational binary-to-reflected-Gray converter.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_encode #(
    parameter int N = 4
) (
    input  wire logic [N-1:0] bin,
    output logic      [N-1:0] gray
);

    // Adjacent binary values map to codes differing in exactly one bit
    assign gray = bin ^ (bin >> 1);

endmodule : gray_encode
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Walks every N_IN-bit input vector (binary or Gray order),
//               holds each for SETTLE cycles, then compares the circuit
//               output against the golden model and tallies mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    truth_table_sweeper_if.slave  bus
);

    localparam logic [7:0]      C_SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [N_IN-1:0] C_IDX_LAST    = {N_IN{1'b1}};

    logic [1:0]      state_q,  state_d;
    logic [7:0]      cnt_q,    cnt_d;
    logic [N_IN-1:0] idx_q,    idx_d;
    logic            mode_q,   mode_d;
    logic [N_IN:0]   err_q,    err_d;
    logic            ffv_q,    ffv_d;
    logic [N_IN-1:0] ffvec_q,  ffvec_d;

    logic [N_IN-1:0]  w_gray;
    logic [N_IN-1:0]  w_vec;
    logic [N_OUT-1:0] w_dut_f;
    logic [N_OUT-1:0] w_ref_f;
    logic             w_mismatch;

    gray_encode #(
        .N (N_IN)
    ) u_gray_encode (
        .bin  (idx_q),
        .gray (w_gray)
    );

    // Stimulus is the index itself or its Gray code, chosen by the latched mode
    assign w_vec      = (mode_q == MODE_GRAY) ? w_gray : idx_q;
    assign w_dut_f    = bus.dut_f;
    assign w_ref_f    = bus.ref_f;
    assign w_mismatch = (w_dut_f != w_ref_f);

    // Next-state logic for the FSM, counters and result registers
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffvec_d = ffvec_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 8'd0;
                    idx_d   = '0;
                    mode_d  = bus.mode;
                    err_d   = '0;
                    ffv_d   = 1'b0;
                    ffvec_d = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == C_SETTLE_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_CHECK: begin
                if (w_mismatch) begin
                    // err_count is one bit wider than idx, so it cannot wrap
                    err_d = err_q + 1'b1;
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = w_vec;
                    end
                end
                if (idx_q == C_IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = 8'd0;
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset discards any partial sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            mode_q  <= MODE_BIN;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
        end
    end

    assign bus.vec_out          = w_vec;
    assign bus.busy             = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign bus.done             = (state_q == ST_DONE);
    assign bus.pass             = (state_q == ST_DONE) && (err_q == '0);
    assign bus.err_count        = err_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_vec   = ffvec_q;

endmodule : truth_table_sweeper
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_sweeper
// Description : Self-checking bench for truth_table_sweeper: default build,
//               N_IN=1/SETTLE=1 build and N_IN=6/N_OUT=3/SETTLE=5 build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    truth_table_sweeper_if #(.N_IN(4), .N_OUT(1)) bus_a ();
    truth_table_sweeper_if #(.N_IN(1), .N_OUT(1)) bus_s ();
    truth_table_sweeper_if #(.N_IN(6), .N_OUT(3)) bus_b ();

    truth_table_sweeper #(.N_IN(4), .N_OUT(1), .SETTLE(2)) u_dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    truth_table_sweeper #(.N_IN(1), .N_OUT(1), .SETTLE(1)) u_dut_s (
        .clk (clk), .rst (rst), .bus (bus_s)
    );
    truth_table_sweeper #(.N_IN(6), .N_OUT(3), .SETTLE(5)) u_dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    // Circuit models: parity reference, faulty copy selected by fault_sel
    int   fault_sel;
    logic fault_bit;
    always_comb begin
        fault_bit = 1'b0;
        case (fault_sel)
            1:       fault_bit = (bus_a.vec_out == 4'd9);
            2:       fault_bit = 1'b1;
            3:       fault_bit = bus_a.vec_out[0];
            default: fault_bit = 1'b0;
        endcase
    end
    assign bus_a.ref_f = ^bus_a.vec_out;
    assign bus_a.dut_f = (^bus_a.vec_out) ^ fault_bit;
    assign bus_s.ref_f = bus_s.vec_out;
    assign bus_s.dut_f = bus_s.vec_out;
    assign bus_b.ref_f = bus_b.vec_out[2:0] + bus_b.vec_out[5:3];
    assign bus_b.dut_f = (bus_b.vec_out[2:0] + bus_b.vec_out[5:3]) ^ {2'b00, bus_b.vec_out[0]};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] code4(input int i, input logic m);
        logic [3:0] b;
        b = 4'(i);
        return m ? (b ^ (b >> 1)) : b;
    endfunction

    typedef struct {
        logic mode;
        int   fault;
        int   exp_err;
        logic exp_ffv;
        int   exp_ffvec;
        logic exp_pass;
        int   inj;        // busy cycle at which to pulse start (-1 = none)
    } vec_t;

    vec_t       tbl[5];
    logic [3:0] exp_q[$];

    // One full sweep of the default build, scoreboarding every new vector
    task automatic sweep_a(input vec_t t);
        int         cyc;
        int         nvec;
        bit         have;
        logic [3:0] prev;
        logic [3:0] e;
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(code4(i, t.mode));
        fault_sel = t.fault;
        @(negedge clk);
        bus_a.start = 1'b1;
        bus_a.mode  = t.mode;
        @(negedge clk);
        bus_a.start = 1'b0;
        bus_a.mode  = ~t.mode;
        cyc = 0; nvec = 0; have = 1'b0; prev = '0;
        while (bus_a.busy && cyc < 200) begin
            if (!have || bus_a.vec_out != prev) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL vec_extra actual=%0d required=none", bus_a.vec_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("vec_seq", bus_a.vec_out, e);
                    chk("vec_time", cyc, nvec * 3);
                    if (t.mode && have) chk("gray_step", $countones(bus_a.vec_out ^ prev), 1);
                end
                prev = bus_a.vec_out;
                have = 1'b1;
                nvec++;
            end
            bus_a.start = (cyc == t.inj);
            cyc++;
            @(negedge clk);
        end
        bus_a.start = 1'b0;
        chk("busy_cycles", cyc, 48);
        chk("done", bus_a.done, 1);
        chk("vec_left", exp_q.size(), 0);
        chk("err_count", bus_a.err_count, t.exp_err);
        chk("ff_valid", bus_a.first_fail_valid, t.exp_ffv);
        chk("ff_vec", bus_a.first_fail_vec, t.exp_ffvec);
        chk("pass", bus_a.pass, t.exp_pass);
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_vec"},   bus_a.vec_out, 0);
        chk({tag, "_busy"},  bus_a.busy, 0);
        chk({tag, "_done"},  bus_a.done, 0);
        chk({tag, "_pass"},  bus_a.pass, 0);
        chk({tag, "_err"},   bus_a.err_count, 0);
        chk({tag, "_ffv"},   bus_a.first_fail_valid, 0);
        chk({tag, "_ffvec"}, bus_a.first_fail_vec, 0);
    endtask

    initial begin
        int w;
        int cyc;
        logic [3:0] v0, v1;
        //            mode fault err ffv ffvec pass inj
        tbl[0] = '{1'b0, 0,  0, 1'b0, 0, 1'b1, -1};
        tbl[1] = '{1'b0, 1,  1, 1'b1, 9, 1'b0, -1};
        tbl[2] = '{1'b1, 2, 16, 1'b1, 0, 1'b0, 20};
        tbl[3] = '{1'b1, 1,  1, 1'b1, 9, 1'b0, -1};
        tbl[4] = '{1'b0, 3,  8, 1'b1, 1, 1'b0,  7};

        rst = 1'b1;
        fault_sel = 0;
        bus_a.start = 1'b0; bus_a.mode = 1'b0;
        bus_s.start = 1'b0; bus_s.mode = 1'b0;
        bus_b.start = 1'b0; bus_b.mode = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_a("reset");
        rst = 1'b0;

        for (int i = 0; i < 5; i++) sweep_a(tbl[i]);

        // Restart from DONE: done drops and results clear on the accepting edge
        chk("pre_restart_err", bus_a.err_count, 8);
        @(negedge clk);
        bus_a.start = 1'b1;
        bus_a.mode  = 1'b0;
        @(negedge clk);
        bus_a.start = 1'b0;
        chk("restart_done", bus_a.done, 0);
        chk("restart_busy", bus_a.busy, 1);
        chk("restart_err",  bus_a.err_count, 0);
        chk("restart_ffv",  bus_a.first_fail_valid, 0);
        chk("restart_vec",  bus_a.vec_out, 0);
        w = 0;
        while (!bus_a.done && w < 100) begin @(negedge clk); w++; end
        chk("restart_finish", bus_a.done, 1);

        // Reset mid-sweep at vector 7 with errors already accumulated
        fault_sel = 2;
        @(negedge clk);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        w = 0;
        while (bus_a.vec_out != 4'd7 && w < 100) begin @(negedge clk); w++; end
        chk("pre_rst_err", bus_a.err_count, 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_a("midrst");
        sweep_a(tbl[0]);

        // Reset and start on the same edge: reset wins
        @(negedge clk);
        rst = 1'b1;
        bus_a.start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_a.start = 1'b0;
        chk("rst_start_busy", bus_a.busy, 0);
        chk("rst_start_done", bus_a.done, 0);

        // N_IN=1, SETTLE=1 corner
        @(negedge clk);
        bus_s.start = 1'b1;
        @(negedge clk);
        bus_s.start = 1'b0;
        cyc = 0; v0 = '1; v1 = '1;
        while (bus_s.busy && cyc < 50) begin
            if (cyc == 0) v0 = 4'(bus_s.vec_out);
            if (cyc == 2) v1 = 4'(bus_s.vec_out);
            cyc++;
            @(negedge clk);
        end
        chk("s_busy_cycles", cyc, 4);
        chk("s_vec0", v0, 0);
        chk("s_vec1", v1, 1);
        chk("s_done", bus_s.done, 1);
        chk("s_pass", bus_s.pass, 1);
        chk("s_err",  bus_s.err_count, 0);

        // N_IN=6, N_OUT=3, SETTLE=5 corner: every odd vector mismatches
        @(negedge clk);
        bus_b.start = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        cyc = 0;
        while (bus_b.busy && cyc < 1000) begin cyc++; @(negedge clk); end
        chk("b_busy_cycles", cyc, 384);
        chk("b_done",  bus_b.done, 1);
        chk("b_err",   bus_b.err_count, 32);
        chk("b_ffv",   bus_b.first_fail_valid, 1);
        chk("b_ffvec", bus_b.first_fail_vec, 1);
        chk("b_pass",  bus_b.pass, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_truth_table_sweeper
`default_nettype wire
